// File: rtl/zynq_tag_serial_tx_if.sv
// Packet handshake between the CSR shell (master) and the tag serializer (slave).
interface zynq_tag_serial_tx_if #(
  parameter int unsigned lg_els_p            = 4,
  parameter int unsigned lg_width_p          = 1,
  parameter int unsigned max_payload_width_p = 1
) ();

  logic                           v;
  logic                           ready_and;
  logic [lg_els_p-1:0]            nodeid;
  logic                           data_not_reset;
  logic [lg_width_p-1:0]          payload_len;
  logic [max_payload_width_p-1:0] payload;

  modport master (
    output v,
    output nodeid,
    output data_not_reset,
    output payload_len,
    output payload,
    input  ready_and
  );

  modport slave (
    input  v,
    input  nodeid,
    input  data_not_reset,
    input  payload_len,
    input  payload,
    output ready_and
  );

endinterface

// File: rtl/zynq_tag_serial_tx.sv
// bsg_tag serial transmitter: emits the ones/zeros preamble after reset, then serializes one
// packet per handshake LSB-first as {payload, nodeid, data_not_reset, payload_len, start}.
module zynq_tag_serial_tx #(
  parameter int unsigned els_p               = 16,
  parameter int unsigned max_payload_width_p = 1,
  parameter int unsigned lg_width_p          = 1,
  parameter int unsigned reset_ones_p        = 8,
  parameter int unsigned reset_zeros_p       = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  zynq_tag_serial_tx_if.slave  pkt_if,
  output logic                 tag_data_o,
  output logic                 done_o,
  output logic                 preamble_done_o
);

  localparam int unsigned lg_els_lp   = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int unsigned hdr_bits_lp = 2 + lg_width_p + lg_els_lp;
  localparam int unsigned pkt_max_lp  = hdr_bits_lp + max_payload_width_p;
  localparam int unsigned pre_max_lp  = (reset_ones_p > reset_zeros_p) ? reset_ones_p
                                                                       : reset_zeros_p;
  localparam int unsigned cnt_max_lp  = (pre_max_lp > pkt_max_lp) ? pre_max_lp : pkt_max_lp;
  localparam int unsigned cnt_w_lp    = $clog2(cnt_max_lp + 1);

  localparam logic [cnt_w_lp-1:0] OnesCnt  = cnt_w_lp'(reset_ones_p);
  localparam logic [cnt_w_lp-1:0] ZerosCnt = cnt_w_lp'(reset_zeros_p);
  localparam logic [cnt_w_lp-1:0] HdrM1    = cnt_w_lp'(hdr_bits_lp - 1);
  localparam logic [cnt_w_lp-1:0] CntOne   = cnt_w_lp'(1);

  typedef enum logic [1:0] {StOnes, StZeros, StIdle, StSend} state_e;

  state_e                  state_q, state_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [pkt_max_lp-2:0]   shift_q, shift_d;
  logic                    tag_data_q, tag_data_d;
  logic                    done_q, done_d;
  logic                    preamble_done_q, preamble_done_d;

  assign pkt_if.ready_and = (state_q == StIdle);
  assign tag_data_o       = tag_data_q;
  assign done_o           = done_q;
  assign preamble_done_o  = preamble_done_q;

  // Next-state logic. tag_data_d is the bit the line shows in the cycle after this edge, so
  // in preamble states the counter tracks bits already launched. In StSend cnt_q holds the
  // number of bits still to launch after the one on the line now.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    tag_data_d      = 1'b0;
    done_d          = 1'b0;
    preamble_done_d = preamble_done_q;
    unique case (state_q)
      StOnes: begin
        if (cnt_q == OnesCnt) begin
          state_d = StZeros;
          cnt_d   = CntOne;
        end else begin
          tag_data_d = 1'b1;
          cnt_d      = cnt_q + CntOne;
        end
      end
      StZeros: begin
        if (cnt_q == ZerosCnt) begin
          state_d         = StIdle;
          cnt_d           = '0;
          preamble_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StIdle: begin
        if (pkt_if.v) begin
          state_d    = StSend;
          tag_data_d = 1'b1;  // start bit goes out directly; the rest waits in the shifter
          shift_d    = {pkt_if.payload, pkt_if.nodeid, pkt_if.data_not_reset,
                        pkt_if.payload_len};
          cnt_d      = HdrM1 + cnt_w_lp'(pkt_if.payload_len);
        end
      end
      StSend: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          tag_data_d = shift_q[0];
          shift_d    = shift_q >> 1;
          cnt_d      = cnt_q - CntOne;
          done_d     = (cnt_q == CntOne);
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= StOnes;
      cnt_q           <= '0;
      shift_q         <= '0;
      tag_data_q      <= 1'b0;
      done_q          <= 1'b0;
      preamble_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shift_q         <= shift_d;
      tag_data_q      <= tag_data_d;
      done_q          <= done_d;
      preamble_done_q <= preamble_done_d;
    end
  end

`ifndef SYNTHESIS
  localparam logic [lg_width_p:0] MaxLen = (lg_width_p + 1)'(max_payload_width_p);

  // Payload lengths beyond the widest client are illegal at accept.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == StIdle) && pkt_if.v) begin
      assert ({1'b0, pkt_if.payload_len} <= MaxLen)
        else $error("payload_len_i exceeds max_payload_width_p");
    end
  end
`endif

endmodule
